// File: rtl/demorgan_sweep_checker.sv
// Exhaustive De Morgan self-test: sweeps every (a, b) pair,
// compares both sides in a registered stage and reports the outcome.
module demorgan_sweep_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2 * WIDTH + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               law,
    input  logic               fault_en,
    input  logic [2*WIDTH-1:0] fault_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH-1:0]   e
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2*WIDTH-1:0] LAST_IDX = '1;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] idx_q, idx_d;
    logic               law_q, law_d;
    logic               fen_q, fen_d;
    logic [2*WIDTH-1:0] fidx_q, fidx_d;

    logic               s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0]   s1_lhs_q, s1_lhs_d;
    logic [WIDTH-1:0]   s1_rhs_q, s1_rhs_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;

    logic [WIDTH-1:0]   e_q, e_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [WIDTH-1:0]   fa_q, fa_d;
    logic [WIDTH-1:0]   fb_q, fb_d;
    logic               ff_q, ff_d;

    logic               accept;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   lhs, rhs;

    // Issue-stage operands and both sides of the selected law
    always_comb begin
        op_a = idx_q[WIDTH-1:0];
        op_b = idx_q[2*WIDTH-1:WIDTH];
        lhs  = law_q ? ~(op_a | op_b) : ~(op_a & op_b);
        rhs  = law_q ? (~op_a & ~op_b) : (~op_a | ~op_b);
        rhs[0] = rhs[0] ^ (fen_q && (idx_q == fidx_q));
    end

    // Sweep control: state, index and latched sweep configuration
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        law_d   = law_q;
        fen_d   = fen_q;
        fidx_d  = fidx_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    idx_d   = '0;
                    law_d   = law;
                    fen_d   = fault_en;
                    fidx_d  = fault_idx;
                end
            end
            RUN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage-1 capture of the issued pair
    always_comb begin
        s1_vld_d = (state_q == RUN);
        s1_lhs_d = s1_lhs_q;
        s1_rhs_d = s1_rhs_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (state_q == RUN) begin
            s1_lhs_d = lhs;
            s1_rhs_d = rhs;
            s1_a_d   = op_a;
            s1_b_d   = op_b;
        end
    end

    // Compare stage: mismatch counting and first-failure capture
    always_comb begin
        e_d   = e_q;
        err_d = err_q;
        fa_d  = fa_q;
        fb_d  = fb_q;
        ff_d  = ff_q;
        if (s1_vld_q) begin
            e_d = s1_lhs_q;
            if (s1_lhs_q != s1_rhs_q) begin
                if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
                if (!ff_q) begin
                    fa_d = s1_a_q;
                    fb_d = s1_b_q;
                    ff_d = 1'b1;
                end
            end
        end
        if (accept) begin
            err_d = '0;
            fa_d  = '0;
            fb_d  = '0;
            ff_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            law_q    <= 1'b0;
            fen_q    <= 1'b0;
            fidx_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_lhs_q <= '0;
            s1_rhs_q <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            e_q      <= '0;
            err_q    <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            ff_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            law_q    <= law_d;
            fen_q    <= fen_d;
            fidx_q   <= fidx_d;
            s1_vld_q <= s1_vld_d;
            s1_lhs_q <= s1_lhs_d;
            s1_rhs_q <= s1_rhs_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            e_q      <= e_d;
            err_q    <= err_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            ff_q     <= ff_d;
        end
    end

    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign pass    = (state_q == DONE) && (err_q == '0);
    assign err_cnt = err_q;
    assign fail_a  = fa_q;
    assign fail_b  = fb_q;
    assign e       = e_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: directed and random sweeps
// checked against a pair-by-pair reference of the De Morgan laws.
module tb_demorgan_sweep_checker;

    localparam int W  = 2;
    localparam int CW = 2 * W + 1;
    localparam int N  = 1 << (2 * W);
    localparam int M  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          law = 1'b0;
    logic          fault_en = 1'b0;
    logic [2*W-1:0] fault_idx = '0;
    logic          busy, done, pass;
    logic [CW-1:0] err_cnt;
    logic [W-1:0]  fail_a, fail_b, e;

    int checks = 0;
    int errors = 0;

    demorgan_sweep_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .law(law),
        .fault_en(fault_en), .fault_idx(fault_idx),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_a(fail_a), .fail_b(fail_b), .e(e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lhs_of(input bit lw, input int p);
        int a = p % (M + 1);
        int b = p / (M + 1);
        return lw ? (~(a | b)) & M : (~(a & b)) & M;
    endfunction

    function automatic int rhs_of(input bit lw, input bit fe,
                                  input int fi, input int p);
        int a = p % (M + 1);
        int b = p / (M + 1);
        int r = lw ? ((~a) & (~b)) & M : ((~a) | (~b)) & M;
        if (fe && p == fi) r = r ^ 1;
        return r;
    endfunction

    task automatic model(input bit lw, input bit fe, input int fi,
                         output int ec, output int fa, output int fb);
        bit found = 0;
        ec = 0; fa = 0; fb = 0;
        for (int p = 0; p < N; p++) begin
            if (lhs_of(lw, p) != rhs_of(lw, fe, fi, p)) begin
                if (ec < (1 << CW) - 1) ec++;
                if (!found) begin
                    fa = p % (M + 1);
                    fb = p / (M + 1);
                    found = 1;
                end
            end
        end
    endtask

    task automatic run_sweep(input bit lw, input bit fe, input int fi,
                             input bit disturb);
        int ec, fa, fb, bcnt;
        model(lw, fe, fi, ec, fa, fb);
        bcnt = 0;
        @(negedge clk);
        law = lw; fault_en = fe; fault_idx = fi[2*W-1:0]; start = 1'b1;
        for (int c = 0; c <= N + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bcnt++;
            if (c == 0) begin
                start = 1'b0;
                chk("start_done_low", done, 0);
                chk("start_err_clr", err_cnt, 0);
                chk("start_fa_clr", fail_a, 0);
                chk("start_fb_clr", fail_b, 0);
            end
            if (disturb && c == 5) begin
                start = 1'b1;
                law = ~lw;
                fault_en = ~fe;
                fault_idx = fault_idx + 3;
            end
            if (disturb && c == 6) start = 1'b0;
            if (c >= 2) chk("e_track", e, lhs_of(lw, c - 2));
            if (c == N) chk("done_not_early", done, 0);
        end
        chk("busy_cycles", bcnt, N + 1);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("err_cnt", err_cnt, ec);
        chk("pass", pass, ec == 0);
        chk("fail_a", fail_a, fa);
        chk("fail_b", fail_b, fb);
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1);
        chk("err_hold", err_cnt, ec);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_fa"}, fail_a, 0);
        chk({tag, "_fb"}, fail_b, 0);
        chk({tag, "_e"}, e, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("idle");

        run_sweep(1'b0, 1'b0, 0, 1'b0);
        run_sweep(1'b1, 1'b0, 0, 1'b0);
        run_sweep(1'b0, 1'b1, 6, 1'b0);
        run_sweep(1'b1, 1'b1, 15, 1'b0);
        run_sweep(1'b0, 1'b1, 0, 1'b0);
        run_sweep(1'b0, 1'b1, 9, 1'b1);
        run_sweep(1'b1, 1'b0, 0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            run_sweep(1'($urandom), 1'($urandom),
                      int'($urandom_range(N - 1, 0)), 1'($urandom));
        end

        @(negedge clk);
        law = 1'b0; fault_en = 1'b1; fault_idx = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_err", err_cnt, 1);
        rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("post_rst");
        run_sweep(1'b0, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_checker.md
Name: demorgan_sweep_checker

Overview:
Parametrised, self-running successor to the single-gate De Morgan lab blocks. It sweeps every operand pair (a, b) of WIDTH bits through an internal counter. For each pair it evaluates both sides of the selected De Morgan law bitwise, then compares them in a registered pipeline stage. It counts mismatches, captures the first failing pair and reports pass/fail, which makes it a board-level self-test for the lab's gate designs. A fault-injection path proves that the checker actually detects errors.

Parameters:
WIDTH, 4, bit width of each operand; the sweep covers N = 2^(2*WIDTH) pairs
CNT_W, 2*WIDTH+1, width of the mismatch counter; the counter saturates at all-ones

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
law  in  1  0: ~(a&b) vs ~a|~b (NAND form); 1: ~(a|b) vs ~a&~b (NOR form)
fault_en  in  1  enable single-point fault injection
fault_idx  in  2*WIDTH  sweep index whose rhs bit 0 is inverted when fault_en=1
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE; held until the next accepted start or reset
pass  out  1  valid while done=1; 1 iff err_cnt==0
err_cnt  out  CNT_W  mismatch count of the current or last sweep
fail_a  out  WIDTH  a operand of the first mismatch (0 if none)
fail_b  out  WIDTH  b operand of the first mismatch (0 if none)
e  out  WIDTH  registered lhs of the pair in the compare stage (observable gate output)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy=0, done=0, pass=0, err_cnt=0, fail_a=0, fail_b=0, e=0. Index and pipeline valid are cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with start=1 at an edge:
  - next state RUN, idx=0;
  - err_cnt, fail_a, fail_b and the first-fail flag are cleared; done=0, pass=0;
  - law, fault_en and fault_idx are latched into shadow registers and held for the whole sweep.
- start while busy=1 is ignored.
- RUN, issue stage (one pair per cycle):
  - a = idx[WIDTH-1:0], b = idx[2*WIDTH-1:WIDTH].
  - lhs = law ? ~(a|b) : ~(a&b).
  - rhs = law ? (~a & ~b) : (~a | ~b); bit 0 of rhs is inverted iff the latched fault_en=1 and idx==latched fault_idx.
  - At the edge, stage-1 registers capture lhs, rhs, a, b and valid=1; idx increments.
  - When idx==N-1 is issued, the next state is DRAIN (idx wraps to 0 and is not reused).
- Compare stage, every cycle with valid=1:
  - e = stage-1 lhs.
  - If lhs!=rhs: err_cnt increments, saturating at 2^CNT_W-1.
  - If lhs!=rhs and the first-fail flag is 0: fail_a/fail_b capture the stage-1 a/b and the flag is set.
- DRAIN: one cycle; the last pair is compared; valid is cleared; next state DONE.
- DONE: done=1, pass=(err_cnt==0), busy=0. err_cnt, fail_a, fail_b and e hold their values.
- Latency: for a start accepted at edge T0, busy is high for the cycles following T0 through T0+N+1. done rises after edge T0+N+1, i.e. N+2 edges after start is sampled.
- Mid-sweep changes to law, fault_en or fault_idx have no effect.
- Reset mid-sweep aborts immediately to IDLE with all outputs at their reset values.
- For correct logic (no fault), err_cnt==0 for both laws and any WIDTH.

Test Plan:
- WIDTH=2, law=0, fault_en=0, pulse start → busy high for 17 cycles; done after N+2=18 edges; pass=1, err_cnt=0, fail_a=fail_b=0.
- WIDTH=2, law=1, fault_en=0 → pass=1, err_cnt=0. e seen on the cycle pair (a=1,b=2) is in compare equals 2'b00.
- WIDTH=2, law=0, fault_en=1, fault_idx=6 → err_cnt=1, pass=0, fail_a=2, fail_b=1.
- WIDTH=2, fault_en=1, fault_idx=15, CNT_W=1 → err_cnt=1, fail_a=3, fail_b=3. Repeat with fault_idx=0 → fail_a=0, fail_b=0.
- start re-asserted mid-sweep and fault_idx changed mid-sweep → no restart, and the result matches the sweep's latched values. Then start in DONE → done drops and a new sweep runs with cleared counters.
- rst_n pulsed low at sweep index 5 → all outputs zero asynchronously, state IDLE. A subsequent start completes a normal sweep with pass=1.
